regfile_write_buffer: RTL and testbench
=======================================

Name: regfile_write_buffer

Overview:
- Write-back stage sitting directly upstream of the 32x64 register array.
- Accepts register write requests (5-bit destination, 64-bit data) over a valid/ready handshake and queues them in a small FIFO.
- Drains at most one write per cycle into the array as a shared 64-bit data bus plus a one-hot 32-bit update vector.
- Provides newest-value forwarding for two read addresses, so consumers see pending writes before they reach the array.

Parameters:
DEPTH, 4, number of queued write entries; power of two, 2..16
CW, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  write request present
in_ready  out  1  buffer can accept request
in_addr  in  5  destination register index
in_data  in  64  write data
drain_en  in  1  permit head entry to be written to array this cycle
wr_data  out  64  data bus to register array
wr_update  out  32  one-hot per-register update enables to register array
rd_addr_a  in  5  forwarding lookup address A
rd_addr_b  in  5  forwarding lookup address B
fwd_hit_a  out  1  pending write to rd_addr_a exists
fwd_data_a  out  64  newest pending data for rd_addr_a
fwd_hit_b  out  1  pending write to rd_addr_b exists
fwd_data_b  out  64  newest pending data for rd_addr_b
count  out  CW  number of queued entries
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Reset is synchronous, active-high, on clk; clock is clk.
- Reset clears the read pointer, write pointer and count. Entry storage is not cleared.
- Reset values: count=0, empty=1, full=0, in_ready=1, wr_update=0, fwd_hit_a/b=0.
- Reset mid-operation drops all queued entries with no array write in that cycle. wr_update is 0 in the cycle after reset.
- in_ready = !full (registered state only). No same-cycle pass-through when full, even if drain_en=1.
- Push: in_valid && in_ready at a rising edge.
  - in_addr != 31: entry stored at the write pointer, which advances with wrap at DEPTH.
  - in_addr == 31 (zero register): accepted and discarded; no enqueue, count unchanged.
- Head outputs are driven combinationally from registered state:
  - wr_data = head data when !empty, else 0.
  - wr_update = (1 << head addr) when !empty && drain_en, else 0.
  - wr_update[31] is never asserted.
- Pop: occurs at a rising edge when !empty && drain_en. The array captures the data on that same edge.
- Latency: a request pushed at edge k is written to the array no earlier than edge k+1. Writes leave strictly in arrival order.
- Simultaneous push and pop: count unchanged. Allowed at any non-full occupancy, including empty-with-push (the pushed entry is not popped that edge).
- Count update: +1 on push only, -1 on pop only.
- Forwarding (combinational):
  - Search all valid entries for addr == rd_addr_x; select the newest match (closest to the write pointer).
  - rd_addr_x == 31 never hits; fwd_data_x = 0.
  - No hit: fwd_hit_x = 0, fwd_data_x = 0.
  - The in_* port is not searched; only already-queued entries are.
  - The head entry being popped this cycle still hits until the edge.
- Occupancy: count, full and empty are derived from registered count only.
- No error on in_valid while full: the request is simply held off by in_ready=0.

Test Plan:
- Reset 2 cycles, then idle → count=0, empty=1, in_ready=1, wr_update=0. Push addr 5, data 9473 with drain_en=0 → count=1. Set drain_en=1 → wr_update=0x00000020, wr_data=9473 for one cycle, then empty=1.
- drain_en=0, push addr 3/7/3/9 with data 1/2/3/4 → full=1, in_ready=0. rd_addr_a=3 → fwd_hit_a=1, fwd_data_a=3. rd_addr_b=8 → fwd_hit_b=0. A 5th push (addr 10) is not accepted.
- From the full state, drain_en=1 for 4 cycles → wr_update sequence 0x8, 0x80, 0x8, 0x200 with data 1, 2, 3, 4; then empty=1 and wr_update=0.
- Push addr 31, data 69 → count stays 0, wr_update[31] never 1. rd_addr_a=31 → fwd_hit_a=0.
- drain_en=1, continuous push every cycle of addr 1..12, data = addr*10 → count stays 1, array receives all 12 writes in order, and pointer wrap-around is exercised.
- Queue 3 entries (drain_en=0), assert reset for 1 cycle with drain_en=1 → no wr_update during or after reset, count=0, fwd_hit_a/b=0.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// Write-back queue in front of the 32x64 register array: in-order drain with
// one-hot update enables, plus newest-value forwarding for two read ports.
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_addr,
    input  logic [63:0]   in_data,
    input  logic          drain_en,
    output logic [63:0]   wr_data,
    output logic [31:0]   wr_update,
    input  logic [4:0]    rd_addr_a,
    input  logic [4:0]    rd_addr_b,
    output logic          fwd_hit_a,
    output logic [63:0]   fwd_data_a,
    output logic          fwd_hit_b,
    output logic [63:0]   fwd_data_b,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [4:0]       addr_q [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic             push, enq, pop;
    logic [DEPTH-1:0] slot_valid, match_a, match_b;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

    // Writes to the zero register are acknowledged but never queued.
    assign push = in_valid && in_ready;
    assign enq  = push && (in_addr != 5'd31);
    assign pop  = !empty && drain_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_valid[gi] = (CW'(PW'(gi) - rd_ptr_q) < count_q);
        assign match_a[gi]    = slot_valid[gi] && (addr_q[gi] == rd_addr_a) && (rd_addr_a != 5'd31);
        assign match_b[gi]    = slot_valid[gi] && (addr_q[gi] == rd_addr_b) && (rd_addr_b != 5'd31);
    end

    // Scan oldest to newest so the last match seen is the youngest write.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_a[rd_ptr_q + PW'(k)]) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = data_q[rd_ptr_q + PW'(k)];
            end
            if (match_b[rd_ptr_q + PW'(k)]) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = data_q[rd_ptr_q + PW'(k)];
            end
        end
    end

    // Reset suppresses the array write even though the head is still present.
    assign wr_data   = empty ? '0 : data_q[rd_ptr_q];
    assign wr_update = (pop && !reset) ? ((32'd1 << addr_q[rd_ptr_q]) & 32'h7FFF_FFFF) : '0;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: vector table plus queue-model scoreboard
// checked every cycle, with hand-written wrap-around and reset sequences.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [63:0]   in_data;
    logic          drain_en;
    logic [63:0]   wr_data;
    logic [31:0]   wr_update;
    logic [4:0]    rd_addr_a;
    logic [4:0]    rd_addr_b;
    logic          fwd_hit_a;
    logic [63:0]   fwd_data_a;
    logic          fwd_hit_b;
    logic [63:0]   fwd_data_b;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    regfile_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .drain_en   (drain_en),
        .wr_data    (wr_data),
        .wr_update  (wr_update),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_data_a (fwd_data_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_b (fwd_data_b),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [63:0] d;
        logic        drn;
        logic [4:0]  ra;
        logic [4:0]  rb;
        int          cnt;
        logic [31:0] upd;
        logic [63:0] wd;
        logic        ha;
        logic [63:0] fa;
        logic        hb;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    vec_t tbl [18];
    ent_t exp_q [$];
    int   total = 0;
    int   passed = 0;
    int   writes_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d,
                         input logic drn, input logic [4:0] ra, input logic [4:0] rb,
                         input logic rst);
        @(negedge clk);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        drain_en  = drn;
        rd_addr_a = ra;
        rd_addr_b = rb;
        reset     = rst;
        #1;
    endtask

    // Compare every output against the queue model, then advance the model across the edge.
    task automatic model_step();
        logic [31:0] e_upd;
        logic [63:0] e_wd, e_fa, e_fb;
        logic        e_ha, e_hb, acc;
        int          sz;
        sz    = exp_q.size();
        e_upd = '0;
        e_wd  = (sz > 0) ? exp_q[0].d : 64'd0;
        if (!reset && drain_en && sz > 0) e_upd = 32'd1 << exp_q[0].a;
        e_ha = 1'b0; e_fa = '0; e_hb = 1'b0; e_fb = '0;
        foreach (exp_q[i]) begin
            if (rd_addr_a != 5'd31 && exp_q[i].a == rd_addr_a) begin e_ha = 1'b1; e_fa = exp_q[i].d; end
            if (rd_addr_b != 5'd31 && exp_q[i].a == rd_addr_b) begin e_hb = 1'b1; e_fb = exp_q[i].d; end
        end
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full", 64'(full), 64'(sz == DEPTH));
        chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
        chk("wr_update", 64'(wr_update), 64'(e_upd));
        chk("wr_upd31", 64'(wr_update[31]), 64'd0);
        chk("wr_data", wr_data, e_wd);
        chk("fwd_hit_a", 64'(fwd_hit_a), 64'(e_ha));
        chk("fwd_data_a", fwd_data_a, e_fa);
        chk("fwd_hit_b", 64'(fwd_hit_b), 64'(e_hb));
        chk("fwd_data_b", fwd_data_b, e_fb);
        if (wr_update != 32'd0) writes_seen++;
        acc = in_valid && (sz < DEPTH);
        if (reset) begin
            exp_q.delete();
        end else begin
            if (drain_en && sz > 0) void'(exp_q.pop_front());
            if (acc && in_addr != 5'd31) exp_q.push_back('{a: in_addr, d: in_data});
        end
        $display("cyc v=%0b a=%0d d=%0d drn=%0b rst=%0b -> cnt=%0d upd=0x%0h wd=%0d",
                 in_valid, in_addr, in_data, drain_en, reset, count, wr_update, wr_data);
        @(posedge clk);
    endtask

    initial begin
        int w0;
        // v a d drn ra rb | cnt upd wd ha fa hb   (expected values sampled before the edge)
        tbl[0]  = '{1'b0, 5'd0,  64'd0,    1'b0, 5'd0,  5'd0, 0, 32'h0,   64'd0,    1'b0, 64'd0,    1'b0};
        tbl[1]  = '{1'b1, 5'd5,  64'd9473, 1'b0, 5'd0,  5'd0, 0, 32'h0,   64'd0,    1'b0, 64'd0,    1'b0};
        tbl[2]  = '{1'b0, 5'd0,  64'd0,    1'b0, 5'd5,  5'd0, 1, 32'h0,   64'd9473, 1'b1, 64'd9473, 1'b0};
        tbl[3]  = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd5,  5'd0, 1, 32'h20,  64'd9473, 1'b1, 64'd9473, 1'b0};
        tbl[4]  = '{1'b0, 5'd0,  64'd0,    1'b0, 5'd5,  5'd0, 0, 32'h0,   64'd0,    1'b0, 64'd0,    1'b0};
        tbl[5]  = '{1'b1, 5'd3,  64'd1,    1'b0, 5'd3,  5'd8, 0, 32'h0,   64'd0,    1'b0, 64'd0,    1'b0};
        tbl[6]  = '{1'b1, 5'd7,  64'd2,    1'b0, 5'd3,  5'd8, 1, 32'h0,   64'd1,    1'b1, 64'd1,    1'b0};
        tbl[7]  = '{1'b1, 5'd3,  64'd3,    1'b0, 5'd3,  5'd8, 2, 32'h0,   64'd1,    1'b1, 64'd1,    1'b0};
        tbl[8]  = '{1'b1, 5'd9,  64'd4,    1'b0, 5'd3,  5'd8, 3, 32'h0,   64'd1,    1'b1, 64'd3,    1'b0};
        tbl[9]  = '{1'b1, 5'd10, 64'd5,    1'b0, 5'd3,  5'd8, 4, 32'h0,   64'd1,    1'b1, 64'd3,    1'b0};
        tbl[10] = '{1'b0, 5'd0,  64'd0,    1'b0, 5'd3,  5'd8, 4, 32'h0,   64'd1,    1'b1, 64'd3,    1'b0};
        tbl[11] = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd3,  5'd8, 4, 32'h8,   64'd1,    1'b1, 64'd3,    1'b0};
        tbl[12] = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd3,  5'd8, 3, 32'h80,  64'd2,    1'b1, 64'd3,    1'b0};
        tbl[13] = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd3,  5'd8, 2, 32'h8,   64'd3,    1'b1, 64'd3,    1'b0};
        tbl[14] = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd3,  5'd8, 1, 32'h200, 64'd4,    1'b0, 64'd0,    1'b0};
        tbl[15] = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd3,  5'd8, 0, 32'h0,   64'd0,    1'b0, 64'd0,    1'b0};
        tbl[16] = '{1'b1, 5'd31, 64'd69,   1'b0, 5'd31, 5'd0, 0, 32'h0,   64'd0,    1'b0, 64'd0,    1'b0};
        tbl[17] = '{1'b0, 5'd0,  64'd0,    1'b0, 5'd31, 5'd0, 0, 32'h0,   64'd0,    1'b0, 64'd0,    1'b0};

        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        drain_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].drn, tbl[i].ra, tbl[i].rb, 1'b0);
            chk($sformatf("t%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("t%0d_upd", i), 64'(wr_update), 64'(tbl[i].upd));
            chk($sformatf("t%0d_wdata", i), wr_data, tbl[i].wd);
            chk($sformatf("t%0d_hit_a", i), 64'(fwd_hit_a), 64'(tbl[i].ha));
            chk($sformatf("t%0d_data_a", i), fwd_data_a, tbl[i].fa);
            chk($sformatf("t%0d_hit_b", i), 64'(fwd_hit_b), 64'(tbl[i].hb));
            model_step();
        end

        // Streaming push+drain: occupancy holds at 1 while the pointers wrap.
        w0 = writes_seen;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 5'(i + 1), 64'((i + 1) * 10), 1'b1, 5'(i + 1), 5'(i), 1'b0);
            chk("stream_count", 64'(count), (i == 0) ? 64'd0 : 64'd1);
            model_step();
        end
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 1'b0);
        chk("stream_last_upd", 64'(wr_update), 64'h1000);
        chk("stream_last_data", wr_data, 64'd120);
        model_step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        chk("stream_writes", 64'(writes_seen - w0), 64'd12);
        chk("stream_empty", 64'(empty), 64'd1);
        model_step();

        // Reset mid-operation with drain enabled.
        drive(1'b1, 5'd4, 64'd40, 1'b0, 5'd4, 5'd6, 1'b0); model_step();
        drive(1'b1, 5'd6, 64'd60, 1'b0, 5'd4, 5'd6, 1'b0); model_step();
        drive(1'b1, 5'd4, 64'd41, 1'b0, 5'd4, 5'd6, 1'b0); model_step();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 5'd6, 1'b1);
        chk("rst_cnt_before", 64'(count), 64'd3);
        chk("rst_upd_during", 64'(wr_update), 64'd0);
        model_step();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 5'd6, 1'b0);
        chk("rst_upd_after", 64'(wr_update), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_hit_a", 64'(fwd_hit_a), 64'd0);
        chk("rst_hit_b", 64'(fwd_hit_b), 64'd0);
        model_step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
